// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and buffer entry type for the fetch stage
package fetch_pkg;
    localparam logic [31:0] PC_RESET     = 32'h0040_0000;
    localparam logic [31:0] PC_INCREMENT = 32'h0000_0004;
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: 2-entry instruction queue with synchronous flush
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t entry_i,
    input  logic         pop_i,
    output fetch_entry_t head_o,
    output logic [1:0]   count_o
);
    fetch_entry_t mem_q [2];
    logic         rd_q, wr_q;
    logic [1:0]   count_q;
    // read/write pointers and occupancy; a flush empties the queue
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            count_q <= 2'd0;
        end else if (flush_i) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            count_q <= 2'd0;
        end else begin
            rd_q    <= rd_q ^ pop_i;
            wr_q    <= wr_q ^ push_i;
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end
    // storage needs no reset: a slot is only observed after it is written
    always_ff @(posedge clock) begin
        if (push_i && !flush_i) mem_q[wr_q] <= entry_i;
    end
    assign head_o  = (count_q != 2'd0) ? mem_q[rd_q] : '0;
    assign count_o = count_q;
    // the upstream credit rule must never let a word arrive into a full queue
    assert property (@(posedge clock) disable iff (reset) !(push_i && count_q == 2'd2));
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, credit-based ROM issue and redirect handling for fetch
module fetch_unit
    import fetch_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect_valid_in,
    input  logic [31:0] redirect_pc_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic [31:0] imem_data_in,
    output logic        inst_valid_out,
    input  logic        inst_ready_in,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc_out,
    output logic [31:0] inst_pc4_out
);
    logic [31:0]  fetch_pc_q, fetch_pc_d, pend_pc_q, pend_pc_d, addr;
    logic         pend_q, pend_d, pend_kill_q, pend_kill_d;
    logic         issue, pop, push, head_valid;
    logic [1:0]   occ;
    logic [2:0]   credit;
    fetch_entry_t head;

    assign head_valid = (occ != 2'd0) & ~redirect_valid_in;
    assign pop        = head_valid & inst_ready_in;
    // slots already claimed after this cycle's pop; below 2 a new word still fits
    assign credit     = {1'b0, occ} + {2'b0, pend_q} - {2'b0, pop};
    assign issue      = redirect_valid_in | (credit < 3'd2);
    assign addr       = redirect_valid_in ? redirect_pc_in : fetch_pc_q;
    assign push       = pend_q & ~pend_kill_q & ~redirect_valid_in;

    // next PC and the tag of the read launched this cycle
    always_comb begin
        fetch_pc_d  = issue ? addr + PC_INCREMENT : fetch_pc_q;
        pend_d      = issue;
        pend_pc_d   = issue ? addr : pend_pc_q;
        pend_kill_d = issue ? 1'b0 : pend_kill_q;
    end

    // PC and outstanding-read state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc_q  <= PC_RESET;
            pend_q      <= 1'b0;
            pend_pc_q   <= '0;
            pend_kill_q <= 1'b0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            pend_q      <= pend_d;
            pend_pc_q   <= pend_pc_d;
            pend_kill_q <= pend_kill_d;
        end
    end

    fetch_buffer u_buf (
        .clock   (clock),
        .reset   (reset),
        .flush_i (redirect_valid_in),
        .push_i  (push),
        .entry_i ('{inst: imem_data_in, pc: pend_pc_q}),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (occ)
    );

    // outputs are forced quiet while reset is held, not just after the next edge
    assign imem_req_out   = issue & ~reset;
    assign imem_addr_out  = reset ? '0 : addr;
    assign inst_valid_out = head_valid & ~reset;
    assign inst_out       = head.inst;
    assign inst_pc_out    = head.pc;
    assign inst_pc4_out   = (occ != 2'd0) ? head.pc + PC_INCREMENT : '0;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed table, async-reset sequence and random run against a queue model
module tb_fetch_unit;
    import fetch_pkg::*;

    typedef struct {
        bit          r;
        logic [31:0] rp;
        bit          rd;
        bit          v;
        logic [31:0] pc;
        bit          q;
        logic [31:0] addr;
    } vec_t;

    logic        clock = 1'b0, reset = 1'b1;
    logic        redirect_valid_in = 1'b0, inst_ready_in = 1'b0;
    logic [31:0] redirect_pc_in = '0, imem_data_in = '0;
    logic        imem_req_out, inst_valid_out;
    logic [31:0] imem_addr_out, inst_out, inst_pc_out, inst_pc4_out;
    int          total = 0, bad = 0;

    logic [31:0] mq[$];
    bit          m_pend;
    logic [31:0] m_pend_pc, m_next, m_stream;

    fetch_unit dut (
        .clock             (clock),
        .reset             (reset),
        .redirect_valid_in (redirect_valid_in),
        .redirect_pc_in    (redirect_pc_in),
        .imem_req_out      (imem_req_out),
        .imem_addr_out     (imem_addr_out),
        .imem_data_in      (imem_data_in),
        .inst_valid_out    (inst_valid_out),
        .inst_ready_in     (inst_ready_in),
        .inst_out          (inst_out),
        .inst_pc_out       (inst_pc_out),
        .inst_pc4_out      (inst_pc4_out)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    always @(posedge clock) imem_data_in <= rom(imem_addr_out);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pend   = 1'b0;
        m_next   = PC_RESET;
        m_stream = PC_RESET;
    endtask

    // drive one cycle's inputs, compare against the model, advance the model
    task automatic drive(input bit r, input logic [31:0] rp, input bit rd);
        bit v, p, q;
        redirect_valid_in = r;
        redirect_pc_in    = rp;
        inst_ready_in     = rd;
        #1;
        v = mq.size() > 0 && !r;
        p = v && rd;
        q = r || (mq.size() + int'(m_pend) - int'(p) < 2);
        chk("valid", 32'(inst_valid_out), 32'(v));
        chk("req", 32'(imem_req_out), 32'(q));
        if (q) chk("addr", imem_addr_out, r ? rp : m_next);
        if (v) begin
            chk("pc", inst_pc_out, mq[0]);
            chk("pc4", inst_pc4_out, mq[0] + 32'd4);
            chk("inst", inst_out, rom(mq[0]));
        end else if (mq.size() == 0) chk("empty_pc", inst_pc_out, 32'd0);
        if (p) begin
            chk("order", inst_pc_out, m_stream);
            m_stream = m_stream + 32'd4;
        end
        if (r) begin
            mq.delete();
            m_stream = rp;
        end else begin
            if (p) void'(mq.pop_front());
            if (m_pend) mq.push_back(m_pend_pc);
        end
        m_pend = q;
        if (q) begin
            m_pend_pc = r ? rp : m_next;
            m_next    = m_pend_pc + 32'd4;
        end
    endtask

    task automatic step(input bit r, input logic [31:0] rp, input bit rd);
        drive(r, rp, rd);
        @(negedge clock);
    endtask

    task automatic async_reset();
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", 32'(inst_valid_out), 32'd0);
        chk("arst_req", 32'(imem_req_out), 32'd0);
        @(negedge clock);
        @(negedge clock);
        redirect_valid_in = 1'b0;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        vec_t tab[20];
        tab = '{
            '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0040_0000},
            '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0040_0004},
            '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0040_0000, 1'b1, 32'h0040_0008},
            '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0040_0004, 1'b1, 32'h0040_000C},
            '{1'b1, 32'h0040_0100, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0040_0100},
            '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0040_0104},
            '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0040_0100, 1'b1, 32'h0040_0108},
            '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0040_0104, 1'b1, 32'h0040_010C},
            '{1'b0, 32'h0, 1'b0, 1'b1, 32'h0040_0108, 1'b0, 32'h0},
            '{1'b0, 32'h0, 1'b0, 1'b1, 32'h0040_0108, 1'b0, 32'h0},
            '{1'b0, 32'h0, 1'b0, 1'b1, 32'h0040_0108, 1'b0, 32'h0},
            '{1'b0, 32'h0, 1'b0, 1'b1, 32'h0040_0108, 1'b0, 32'h0},
            '{1'b0, 32'h0, 1'b0, 1'b1, 32'h0040_0108, 1'b0, 32'h0},
            '{1'b0, 32'h0, 1'b0, 1'b1, 32'h0040_0108, 1'b0, 32'h0},
            '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0040_0108, 1'b1, 32'h0040_0110},
            '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0040_010C, 1'b1, 32'h0040_0114},
            '{1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC},
            '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0000},
            '{1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0000_0004},
            '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 32'h0000_0008}
        };
        repeat (2) @(negedge clock);
        chk("rst_valid", 32'(inst_valid_out), 32'd0);
        chk("rst_req", 32'(imem_req_out), 32'd0);
        chk("rst_addr", imem_addr_out, 32'd0);
        chk("rst_inst", inst_out, 32'd0);
        chk("rst_pc", inst_pc_out, 32'd0);
        chk("rst_pc4", inst_pc4_out, 32'd0);
        reset = 1'b0;
        model_reset();
        foreach (tab[i]) begin
            drive(tab[i].r, tab[i].rp, tab[i].rd);
            chk("t_valid", 32'(inst_valid_out), 32'(tab[i].v));
            chk("t_req", 32'(imem_req_out), 32'(tab[i].q));
            if (tab[i].v) chk("t_pc", inst_pc_out, tab[i].pc);
            if (tab[i].q) chk("t_addr", imem_addr_out, tab[i].addr);
            @(negedge clock);
        end
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b0);
        async_reset();
        drive(1'b0, 32'h0, 1'b1);
        chk("post_rst_addr", imem_addr_out, PC_RESET);
        @(negedge clock);
        for (int n = 0; n < 3000; n++) begin
            bit          r;
            logic [31:0] rp;
            r  = $urandom_range(0, 9) == 0;
            rp = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + ($urandom_range(0, 3) << 2)
                                             : ($urandom & 32'hFFFF_FFFC);
            step(r, rp, $urandom_range(0, 3) != 0);
            if (n == 1500) async_reset();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
